// File: rtl/wb_retire_buffer.sv
// wb_retire_buffer
//   In-order writeback retire buffer. Completed results are queued as
//   {wen, rd, data} entries and written to the register file one per cycle
//   from the head of a DEPTH-slot FIFO. Pending entries can be looked up by
//   register index so younger instructions see results that have not reached
//   the register file yet.
//
//   Optional feature: define WB_RETIRE_CNT_EN to build a 32-bit retired-entry
//   counter on retire_cnt; without it retire_cnt is tied to zero and no counter
//   register exists.
//
// Ports
//   clock       single clock, all state on rising edge
//   reset       asynchronous active-low reset, released synchronously upstream
//   in_valid    writeback entry offered
//   in_ready    buffer can accept an entry (not full)
//   in_wen      entry writes a destination register
//   in_rd       destination register index
//   in_data     result value
//   hold        freezes retirement (debug halt); pushes still accepted
//   rf_en       register-file write enable
//   rf_addr     register-file write index (head slot)
//   rf_data     register-file write data (head slot)
//   fwd_addr    forwarding lookup index
//   fwd_hit     lookup matched a pending entry
//   fwd_data    forwarded value from the youngest match, 0 on miss
//   retire_cnt  count of retired entries

module wb_retire_buffer #(
  parameter int REG_NUM_WIDTH  = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int DEPTH          = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_wen,
  input  logic [REG_NUM_WIDTH-1:0]  in_rd,
  input  logic [REG_DATA_WIDTH-1:0] in_data,
  input  logic                      hold,
  output logic                      rf_en,
  output logic [REG_NUM_WIDTH-1:0]  rf_addr,
  output logic [REG_DATA_WIDTH-1:0] rf_data,
  input  logic [REG_NUM_WIDTH-1:0]  fwd_addr,
  output logic                      fwd_hit,
  output logic [REG_DATA_WIDTH-1:0] fwd_data,
  output logic [31:0]               retire_cnt
);

  localparam int AW = $clog2(DEPTH);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PW = AW + 1;

  logic                      wen_mem_r  [DEPTH];
  logic [REG_NUM_WIDTH-1:0]  rd_mem_r   [DEPTH];
  logic [REG_DATA_WIDTH-1:0] data_mem_r [DEPTH];

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] count_s;
  logic [AW-1:0] head_s;
  logic [AW-1:0] tail_s;
  logic [AW-1:0] slot_s;
  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;

  assign head_s  = rd_ptr_r[AW-1:0];
  assign tail_s  = wr_ptr_r[AW-1:0];
  assign count_s = wr_ptr_r - rd_ptr_r;
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

  // in_ready depends on occupancy only, so a full buffer refuses a push even
  // in a cycle where the head is popping.
  assign in_ready = ~full_s;
  assign push_s   = in_valid & ~full_s;
  assign pop_s    = ~empty_s & ~hold;

  assign rf_addr = rd_mem_r[head_s];
  assign rf_data = data_mem_r[head_s];
  // Entries to x0 or without wen still pop; they just never write.
  assign rf_en   = pop_s & wen_mem_r[head_s] & (rd_mem_r[head_s] != '0);

  // Read/write pointer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Slot storage; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge clock) begin
    if (push_s) begin
      wen_mem_r[tail_s]  <= in_wen;
      rd_mem_r[tail_s]   <= in_rd;
      data_mem_r[tail_s] <= in_data;
    end
  end

  // Forwarding lookup: scan oldest to youngest so the youngest match wins.
  // The head is included even while it is being written this cycle.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot_s   = head_s;
    for (int i = 0; i < DEPTH; i++) begin
      slot_s = head_s + AW'(i);
      if ((PW'(i) < count_s) && wen_mem_r[slot_s] &&
          (rd_mem_r[slot_s] == fwd_addr) && (fwd_addr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem_r[slot_s];
      end else begin
        fwd_hit  = fwd_hit;
        fwd_data = fwd_data;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] cnt_r;

  // Retired-entry counter, wraps naturally at 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= 32'd0;
    end else if (pop_s) begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  assign retire_cnt = cnt_r;
`else
  assign retire_cnt = 32'd0;
`endif

endmodule

// File: doc/wb_retire_buffer.md
WB_RETIRE_BUFFER -- requirements
Module: wb_retire_buffer

Interface
REQ-001 SHALL have parameter REG_NUM_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter REG_DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter DEPTH, default 4, number of retire entries; power of two and at least 2.
REQ-004 SHALL have port: clock  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: in_valid  in  1  writeback entry offered.
REQ-007 SHALL have port: in_ready  out  1  buffer can accept an entry.
REQ-008 SHALL have port: in_wen  in  1  entry writes a destination register.
REQ-009 SHALL have port: in_rd  in  REG_NUM_WIDTH  destination register index.
REQ-010 SHALL have port: in_data  in  REG_DATA_WIDTH  result value.
REQ-011 SHALL have port: hold  in  1  freezes retirement (debug halt).
REQ-012 SHALL have port: rf_en  out  1  register-file write enable.
REQ-013 SHALL have port: rf_addr  out  REG_NUM_WIDTH  register-file write index.
REQ-014 SHALL have port: rf_data  out  REG_DATA_WIDTH  register-file write data.
REQ-015 SHALL have port: fwd_addr  in  REG_NUM_WIDTH  forwarding lookup index.
REQ-016 SHALL have port: fwd_hit  out  1  lookup matched a pending entry.
REQ-017 SHALL have port: fwd_data  out  REG_DATA_WIDTH  forwarded value.
REQ-018 SHALL have port: retire_cnt  out  32  count of retired entries.

Function
REQ-019 SHALL hold entries in an in-order FIFO of DEPTH slots, storing {wen, rd, data} per slot.
REQ-020 SHALL drive in_ready = not full; no combinational dependence on pop.
REQ-021 SHALL push on a rising edge when in_valid and in_ready are both high.
REQ-022 SHALL pop the head when non-empty and hold low, at most one pop per cycle.
REQ-023 SHALL drive rf_addr and rf_data combinationally from the head slot.
REQ-024 SHALL drive rf_en = pop and head.wen and head.rd != 0; the x0 and no-wen entries still retire.
REQ-025 SHALL give one-cycle latency: an entry pushed at edge N appears on rf_* in cycle N+1 and is written at edge N+1 if not held.
REQ-026 SHALL, on a simultaneous push and pop (not full, not empty), leave occupancy unchanged.
REQ-027 SHALL, when full, reject the push even if a pop occurs the same cycle.
REQ-028 SHALL wrap read and write pointers modulo DEPTH, using an extra bit to distinguish full from empty.
REQ-029 SHALL set fwd_hit when any valid slot has wen=1, rd == fwd_addr and fwd_addr != 0.
REQ-030 SHALL drive fwd_data from the youngest matching slot; fwd_data = 0 when fwd_hit = 0.
REQ-031 SHALL include the head slot in forwarding while it is still being written to the register file.
REQ-032 SHALL, with hold high, freeze pointers and retire_cnt, force rf_en = 0, and keep accepting pushes until full.

Reset
REQ-033 SHALL, on reset low, clear pointers and retire_cnt asynchronously; in_ready=1, rf_en=0, fwd_hit=0.
REQ-034 SHALL discard all pending entries on reset asserted mid-operation; slot data need not be cleared.
REQ-035 SHALL release from reset synchronously to clock.

Configuration
REQ-036 SHALL, with macro WB_RETIRE_CNT_EN defined, increment retire_cnt by 1 per pop, wrapping from 0xFFFFFFFF to 0.
REQ-037 SHALL, without WB_RETIRE_CNT_EN, tie retire_cnt to 0 and instantiate no counter register.

Verification
REQ-038 SHALL cover: push {wen=1, rd=5, data=0xDEADBEEF}, hold=0 -> next cycle rf_en=1, rf_addr=5, rf_data=0xDEADBEEF; retire_cnt=1.
REQ-039 SHALL cover: push {wen=1, rd=0, data=0x1234} -> rf_en stays 0, the entry pops, retire_cnt increments.
REQ-040 SHALL cover: hold=1, push 5 entries with DEPTH=4 -> in_ready=0 after the 4th push; release hold -> 4 writes in order on consecutive cycles.
REQ-041 SHALL cover: pending rd=7 entries with data 0x11 then 0x22, fwd_addr=7 -> fwd_hit=1, fwd_data=0x22; fwd_addr=0 -> fwd_hit=0.
REQ-042 SHALL cover: reset low with 3 entries pending -> in_ready=1, rf_en=0, retire_cnt=0 immediately; after release, no stale write occurs.
REQ-043 SHALL cover: retire_cnt preset via 2^32 pops, or forced to 0xFFFFFFFF, then one pop -> retire_cnt=0 (macro defined); without the macro it stays 0 throughout.
